lcd_stream_display: RTL and testbench

LCD_STREAM_DISPLAY -- requirements
Module: lcd_stream_display

---
 rtl/lcd_stream_display_pkg.sv | 37 +++
 rtl/lcd_stream_display_pix_fifo.sv | 72 +++++++
 rtl/lcd_stream_display.sv | 177 +++++++++++++++++
 tb/tb_lcd_stream_display.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_stream_display_pkg.sv
// Shared definitions for the LCD stream display: default panel timing,
// output mode encoding and the colour bar palette.
package lcd_stream_display_pkg;

  localparam int DEF_H_ACTIVE   = 800;
  localparam int DEF_H_FP       = 210;
  localparam int DEF_H_BLANK    = 46;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 22;
  localparam int DEF_V_BLANK    = 23;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_e;

  // Bar palette as {R,G,B} on/off flags, left to right on the screen.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;  // white
      3'd1:    m = 3'b110;  // yellow
      3'd2:    m = 3'b011;  // cyan
      3'd3:    m = 3'b010;  // green
      3'd4:    m = 3'b101;  // magenta
      3'd5:    m = 3'b100;  // red
      3'd6:    m = 3'b001;  // blue
      default: m = 3'b000;  // black
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lcd_stream_display_pix_fifo.sv
// Pixel prefetch FIFO: first-word-fall-through read, synchronous flush that
// overrides any push or pop in the same cycle, and push-while-full accepted
// when a pop frees the slot in the same cycle.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointer/occupancy; flush returns everything to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lcd_stream_display.sv
// LCD timing generator with streamed pixel input. Free-running x/y raster
// counters drive sync/enable and pick the pixel source (FIFO stream, colour
// bars, solid colour or black); video outputs are two register stages behind
// the counters, frame strobes are combinational from the counters.
module lcd_stream_display
  import lcd_stream_display_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_BLANK    = DEF_V_BLANK,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic [3*PIX_W-1:0] iPIX_DATA,
  input  logic               iPIX_VALID,
  output logic               oPIX_READY,
  input  logic [1:0]         iMODE,
  input  logic [3*PIX_W-1:0] iSOLID,
  input  logic               iCLR_UNDERFLOW,
  output logic               oHD,
  output logic               oVD,
  output logic               oDE,
  output logic [PIX_W-1:0]   oLCD_R,
  output logic [PIX_W-1:0]   oLCD_G,
  output logic [PIX_W-1:0]   oLCD_B,
  output logic               oNew_Frame,
  output logic               oEnd_Frame,
  output logic [10:0]        o_current_x,
  output logic [9:0]         o_current_y,
  output logic               oUNDERFLOW
);

  localparam int H_LINE = H_BLANK + H_ACTIVE + H_FP;
  localparam int V_LINE = V_BLANK + V_ACTIVE + V_FP;
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int CW     = 3 * PIX_W;

  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  mode_e         mode_q, mode_d;
  logic          und_q, und_d;

  logic          new_frame, active;
  logic          stream_pop, underflow_evt;
  logic          fifo_full, fifo_empty, fifo_push;
  logic [CW-1:0] fifo_data;

  logic [10:0]   x_off;
  logic [2:0]    bar_idx, bar_rgb;
  logic [CW-1:0] pix_d;

  logic          hd1_q, vd1_q, de1_q;
  logic [CW-1:0] pix1_q;
  logic          hd2_q, vd2_q, de2_q;
  logic [CW-1:0] pix2_q;

  assign new_frame  = (x_q == '0) && (y_q == '0);
  assign oNew_Frame = new_frame;
  assign oEnd_Frame = (x_q == 11'(H_BLANK + H_ACTIVE - 1)) &&
                      (y_q == 10'(V_BLANK + V_ACTIVE - 1));

  assign active = (x_q >= 11'(H_BLANK)) && (x_q < 11'(H_BLANK + H_ACTIVE)) &&
                  (y_q >= 10'(V_BLANK)) && (y_q < 10'(V_BLANK + V_ACTIVE));

  // Flush at frame start wins over any offered pixel, so ready drops there.
  assign oPIX_READY    = !fifo_full && !new_frame;
  assign fifo_push     = iPIX_VALID && oPIX_READY;
  assign stream_pop    = active && (mode_q == MODE_STREAM);
  assign underflow_evt = stream_pop && fifo_empty;

  pix_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_n_i (iRST_n),
    .flush_i (new_frame),
    .push_i  (fifo_push),
    .data_i  (iPIX_DATA),
    .pop_i   (stream_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Raster position: x wraps at line end and carries into y.
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == 11'(H_LINE - 1)) begin
      x_d = '0;
      y_d = (y_q == 10'(V_LINE - 1)) ? '0 : y_q + 10'd1;
    end
  end

  // Mode is latched only at frame start; underflow is sticky, set beats clear.
  always_comb begin
    mode_d = new_frame ? mode_e'(iMODE) : mode_q;
    und_d  = und_q;
    if (underflow_evt)       und_d = 1'b1;
    else if (iCLR_UNDERFLOW) und_d = 1'b0;
  end

  assign x_off   = x_q - 11'(H_BLANK);
  assign bar_idx = 3'(x_off / 11'(BAR_W));
  assign bar_rgb = bar_mask(bar_idx);

  // Pixel source select; everything outside the active area is black.
  always_comb begin
    pix_d = '0;
    if (active) begin
      case (mode_q)
        MODE_STREAM: if (!fifo_empty) pix_d = fifo_data;
        MODE_BARS: begin
          if (x_off < 11'(8 * BAR_W))
            pix_d = {{PIX_W{bar_rgb[2]}}, {PIX_W{bar_rgb[1]}}, {PIX_W{bar_rgb[0]}}};
        end
        MODE_SOLID:  pix_d = iSOLID;
        default:     pix_d = '0;
      endcase
    end
  end

  // Counter, mode and underflow state.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= MODE_STREAM;
      und_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      und_q  <= und_d;
    end
  end

  // Two-stage video pipeline; reset values are the idle panel levels.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hd1_q  <= 1'b0;
      vd1_q  <= 1'b1;
      de1_q  <= 1'b0;
      pix1_q <= '0;
      hd2_q  <= 1'b0;
      vd2_q  <= 1'b1;
      de2_q  <= 1'b0;
      pix2_q <= '0;
    end else begin
      hd1_q  <= (x_q != '0);
      vd1_q  <= (y_q != '0);
      de1_q  <= active;
      pix1_q <= pix_d;
      hd2_q  <= hd1_q;
      vd2_q  <= vd1_q;
      de2_q  <= de1_q;
      pix2_q <= pix1_q;
    end
  end

  assign oHD         = hd2_q;
  assign oVD         = vd2_q;
  assign oDE         = de2_q;
  assign oLCD_R      = pix2_q[3*PIX_W-1:2*PIX_W];
  assign oLCD_G      = pix2_q[2*PIX_W-1:PIX_W];
  assign oLCD_B      = pix2_q[PIX_W-1:0];
  assign o_current_x = x_q;
  assign o_current_y = y_q;
  assign oUNDERFLOW  = und_q;

endmodule

// File: tb/tb_lcd_stream_display.sv
// Bench for lcd_stream_display on a shrunken raster. A queue-based model
// computes the expected raster position, strobes, ready, underflow and the
// delayed video from the timing rules; colour bars are also checked from a
// hand-written vector table, plus directed underflow/mode/reset sequences.
module tb_lcd_stream_display;
  import lcd_stream_display_pkg::*;

  localparam int HA = 20, HFP = 3, HB = 5;
  localparam int VA = 6, VFP = 2, VB = 3;
  localparam int PW = 8, DEP = 4;
  localparam int HL = HB + HA + HFP;
  localparam int VL = VB + VA + VFP;
  localparam int FR = HL * VL;
  localparam int BW = HA / 8;
  localparam int CW = 3 * PW;

  logic          iCLK = 1'b0;
  logic          iRST_n = 1'b0;
  logic [CW-1:0] iPIX_DATA = '0;
  logic          iPIX_VALID = 1'b0;
  logic          oPIX_READY;
  logic [1:0]    iMODE = 2'd0;
  logic [CW-1:0] iSOLID = '0;
  logic          iCLR_UNDERFLOW = 1'b0;
  logic          oHD, oVD, oDE, oNew_Frame, oEnd_Frame, oUNDERFLOW;
  logic [PW-1:0] oLCD_R, oLCD_G, oLCD_B;
  logic [10:0]   o_current_x;
  logic [9:0]    o_current_y;

  always #5 iCLK = ~iCLK;

  lcd_stream_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_BLANK(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_BLANK(VB),
    .PIX_W(PW), .FIFO_DEPTH(DEP)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iPIX_DATA(iPIX_DATA), .iPIX_VALID(iPIX_VALID), .oPIX_READY(oPIX_READY),
    .iMODE(iMODE), .iSOLID(iSOLID), .iCLR_UNDERFLOW(iCLR_UNDERFLOW),
    .oHD(oHD), .oVD(oVD), .oDE(oDE),
    .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
    .oNew_Frame(oNew_Frame), .oEnd_Frame(oEnd_Frame),
    .o_current_x(o_current_x), .o_current_y(o_current_y),
    .oUNDERFLOW(oUNDERFLOW)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          hd;
    logic          vd;
    logic          de;
    logic [CW-1:0] rgb;
  } vid_t;

  logic [CW-1:0] bar_tbl [8];
  logic [CW-1:0] q [$];
  int            t;
  logic [1:0]    mode_m;
  logic          und_m;
  vid_t          p1, p2;
  bit            last_xfer;
  int            src_idx = 0;
  int            valid_pct = 100, clr_pct = 0, mode_pct = 0;
  int            de_cnt, hd_low, vd_low;

  task automatic model_reset();
    t = 0;
    q.delete();
    mode_m = 2'd0;
    und_m  = 1'b0;
    p1 = '{hd: 1'b0, vd: 1'b1, de: 1'b0, rgb: '0};
    p2 = p1;
    last_xfer = 1'b0;
  endtask

  task automatic step();
    int x, y;
    bit nf, ef, rdy, act, under;
    vid_t cur;
    x  = t % HL;
    y  = (t / HL) % VL;
    nf = (x == 0) && (y == 0);
    ef = (x == HB + HA - 1) && (y == VB + VA - 1);
    rdy = !nf && (q.size() < DEP);
    act = (x >= HB) && (x < HB + HA) && (y >= VB) && (y < VB + VA);
    chk("x", 32'(o_current_x), 32'(x));
    chk("y", 32'(o_current_y), 32'(y));
    chk("new_frame", 32'(oNew_Frame), 32'(nf));
    chk("end_frame", 32'(oEnd_Frame), 32'(ef));
    chk("ready", 32'(oPIX_READY), 32'(rdy));
    chk("underflow", 32'(oUNDERFLOW), 32'(und_m));
    chk("hd", 32'(oHD), 32'(p2.hd));
    chk("vd", 32'(oVD), 32'(p2.vd));
    chk("de", 32'(oDE), 32'(p2.de));
    chk("rgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(p2.rgb));
    de_cnt += int'(oDE);
    hd_low += int'(!oHD);
    vd_low += int'(!oVD);
    cur.hd  = (x != 0);
    cur.vd  = (y != 0);
    cur.de  = act;
    cur.rgb = '0;
    under   = 1'b0;
    if (act) begin
      case (mode_m)
        2'd0: if (q.size() == 0) under = 1'b1; else cur.rgb = q.pop_front();
        2'd1: if (x - HB < 8 * BW) cur.rgb = bar_tbl[(x - HB) / BW];
        2'd2: cur.rgb = iSOLID;
        default: cur.rgb = '0;
      endcase
    end
    last_xfer = iPIX_VALID && rdy;
    if (nf) q.delete();
    else if (last_xfer) q.push_back(iPIX_DATA);
    if (under) und_m = 1'b1;
    else if (iCLR_UNDERFLOW) und_m = 1'b0;
    if (nf) mode_m = iMODE;
    p2 = p1;
    p1 = cur;
    t++;
  endtask

  // One clock: model/check at the falling edge, new stimulus 1 after rising.
  task automatic cyc();
    @(negedge iCLK);
    step();
    @(posedge iCLK);
    #1;
    if (last_xfer) src_idx++;
    iPIX_DATA      = CW'(src_idx);
    iPIX_VALID     = ($urandom_range(99) < valid_pct);
    iCLR_UNDERFLOW = ($urandom_range(99) < clr_pct);
    if ($urandom_range(99) < mode_pct) begin
      iMODE  = 2'($urandom_range(3));
      iSOLID = CW'($urandom);
    end
  endtask

  // Advance until the next cycle to be modelled sits at raster (xx, yy).
  task automatic run_to(input int xx, input int yy);
    int guard = 0;
    while (!((t % HL) == xx && ((t / HL) % VL) == yy)) begin
      cyc();
      guard++;
      if (guard > 2 * FR) begin
        n_checks++;
        n_fail++;
        $display("FAIL run_to timeout: position (%0d,%0d) not reached", xx, yy);
        break;
      end
    end
  endtask

  typedef struct {
    int            off;
    logic [CW-1:0] rgb;
  } bar_vec_t;

  bar_vec_t bvec [13];
  logic [CW-1:0] solid_val;

  initial begin
    bar_tbl[0] = 24'hFFFFFF; bar_tbl[1] = 24'hFFFF00;
    bar_tbl[2] = 24'h00FFFF; bar_tbl[3] = 24'h00FF00;
    bar_tbl[4] = 24'hFF00FF; bar_tbl[5] = 24'hFF0000;
    bar_tbl[6] = 24'h0000FF; bar_tbl[7] = 24'h000000;

    bvec[0]  = '{0,  24'hFFFFFF};
    bvec[1]  = '{1,  24'hFFFFFF};
    bvec[2]  = '{2,  24'hFFFF00};
    bvec[3]  = '{3,  24'hFFFF00};
    bvec[4]  = '{4,  24'h00FFFF};
    bvec[5]  = '{6,  24'h00FF00};
    bvec[6]  = '{8,  24'hFF00FF};
    bvec[7]  = '{10, 24'hFF0000};
    bvec[8]  = '{12, 24'h0000FF};
    bvec[9]  = '{14, 24'h000000};
    bvec[10] = '{16, 24'h000000};
    bvec[11] = '{17, 24'h000000};
    bvec[12] = '{19, 24'h000000};

    de_cnt = 0; hd_low = 0; vd_low = 0;

    // Reset values while held in reset.
    iMODE = 2'd1;
    #12;
    chk("rst_hd", 32'(oHD), 32'd0);
    chk("rst_vd", 32'(oVD), 32'd1);
    chk("rst_de", 32'(oDE), 32'd0);
    chk("rst_rgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
    chk("rst_ready", 32'(oPIX_READY), 32'd0);
    chk("rst_x", 32'(o_current_x), 32'd0);
    chk("rst_y", 32'(o_current_y), 32'd0);
    chk("rst_underflow", 32'(oUNDERFLOW), 32'd0);

    @(posedge iCLK);
    #1;
    iRST_n = 1'b1;
    model_reset();

    // Colour bars from the vector table; sampled 1 after the edge that
    // presents raster column HB+off.
    for (int i = 0; i < 13; i++) begin
      run_to(HB + bvec[i].off + 2, VB + 1);
      chk($sformatf("bar_off%0d", bvec[i].off), 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(bvec[i].rgb));
    end

    // Random phase: mixed modes, source gaps and clears.
    iMODE = 2'd0;
    mode_pct = 1; clr_pct = 3;
    for (int f = 0; f < 4; f++) begin
      valid_pct = (f == 0) ? 100 : 60 + 10 * f;
      for (int c = 0; c < FR; c++) cyc();
    end
    mode_pct = 0; clr_pct = 0; valid_pct = 100;
    iMODE = 2'd0;
    run_to(0, 0);
    for (int c = 0; c < FR; c++) cyc();

    // Free-run frame totals.
    de_cnt = 0; hd_low = 0; vd_low = 0;
    for (int c = 0; c < FR; c++) cyc();
    chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
    chk("hd_low_per_frame", 32'(hd_low), 32'(VL));
    chk("vd_low_per_frame", 32'(vd_low), 32'(HL));

    // Underflow: clear in blanking, starve 40 active cycles, stays sticky.
    run_to(0, 1);
    iCLR_UNDERFLOW = 1'b1;
    cyc();
    chk("und_cleared", 32'(oUNDERFLOW), 32'd0);
    run_to(0, VB + 1);
    valid_pct = 0;
    iPIX_VALID = 1'b0;
    for (int c = 0; c < 2 * HL; c++) cyc();
    chk("und_set", 32'(oUNDERFLOW), 32'd1);
    valid_pct = 100;
    run_to(0, VB + 4);
    chk("und_sticky", 32'(oUNDERFLOW), 32'd1);
    run_to(0, 1);
    iCLR_UNDERFLOW = 1'b1;
    cyc();
    chk("und_clr", 32'(oUNDERFLOW), 32'd0);

    // Mid-frame mode change takes effect only at the next frame.
    run_to(HB + 5, VB + 1);
    solid_val = 24'h3C5A96;
    iMODE  = 2'd2;
    iSOLID = solid_val;
    run_to(HB + 2, VB);
    chk("solid_next_frame", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(solid_val));
    iMODE = 2'd0;
    run_to(0, 0);
    cyc();

    // Reset mid-frame: outputs go to reset levels immediately.
    run_to(HB + 8, VB + 2);
    iRST_n = 1'b0;
    #2;
    chk("mid_rst_hd", 32'(oHD), 32'd0);
    chk("mid_rst_vd", 32'(oVD), 32'd1);
    chk("mid_rst_de", 32'(oDE), 32'd0);
    chk("mid_rst_rgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
    chk("mid_rst_ready", 32'(oPIX_READY), 32'd0);
    chk("mid_rst_x", 32'(o_current_x), 32'd0);
    chk("mid_rst_y", 32'(o_current_y), 32'd0);
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    iRST_n = 1'b1;
    model_reset();
    valid_pct = 80; clr_pct = 2;
    for (int c = 0; c < 2 * FR; c++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
